// File: rtl/cavlc_coeff_rebuild_pkg.sv
// Shared constants for CAVLC coefficient reconstruction: widths, FSM encodings
// and the start-time syntax check.
package cavlc_coeff_rebuild_pkg;

    localparam int RES_WIDTH_DEF = 16;
    localparam int MAX_COEFF     = 16;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_EMIT = 2'd2;

    // trailing_ones is at most 3, so exceeding min(3, total_coeff) reduces to exceeding total_coeff
    function automatic logic start_bad(input logic [4:0] tc, input logic [1:0] t1,
                                       input logic [3:0] tz);
        return (({1'b0, tc} + {2'b00, tz}) > 6'(MAX_COEFF)) || ({3'b000, t1} > tc);
    endfunction

endpackage

// File: rtl/cavlc_coeff_rebuild_place.sv
// Combinational placement step for one level/run element: level select,
// run clamp against the remaining zeros, and next position bookkeeping.
module cavlc_coeff_place
    import cavlc_coeff_rebuild_pkg::*;
#(
    parameter int RES_WIDTH = RES_WIDTH_DEF
) (
    input  logic [4:0]                  elem_cnt_i,
    input  logic [4:0]                  total_coeff_i,
    input  logic [1:0]                  trailing_ones_i,
    input  logic [2:0]                  t1_signs_i,
    input  logic signed [RES_WIDTH-1:0] elem_level_i,
    input  logic [3:0]                  elem_run_i,
    input  logic [4:0]                  pos_i,
    input  logic [3:0]                  zeros_left_i,
    output logic signed [RES_WIDTH-1:0] level_o,
    output logic [4:0]                  pos_next_o,
    output logic [3:0]                  zeros_left_next_o,
    output logic                        last_o,
    output logic                        run_err_o
);

    logic [3:0] run;

    always_comb begin
        last_o    = (elem_cnt_i == (total_coeff_i - 5'd1));
        run       = 4'd0;
        run_err_o = 1'b0;

        if ({3'b000, trailing_ones_i} > elem_cnt_i) begin
            level_o = t1_signs_i[elem_cnt_i[1:0]] ? {RES_WIDTH{1'b1}}
                                                   : {{(RES_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            level_o = elem_level_i;
        end

        // The last element's run is implicit: remaining zeros sit below it
        if (!last_o) begin
            if (elem_run_i > zeros_left_i) begin
                run       = zeros_left_i;
                run_err_o = 1'b1;
            end else begin
                run = elem_run_i;
            end
        end

        pos_next_o        = pos_i - 5'd1 - {1'b0, run};
        zeros_left_next_o = zeros_left_i - run;
    end

endmodule

// File: rtl/cavlc_coeff_rebuild.sv
// CAVLC 4x4 coefficient rebuild: places reverse-zigzag level/run elements
// into a 16-entry array, then emits zigzag pairs (0,1)..(14,15).
module cavlc_coeff_rebuild
    import cavlc_coeff_rebuild_pkg::*;
#(
    parameter int RES_WIDTH = RES_WIDTH_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [4:0]                  total_coeff,
    input  logic [1:0]                  trailing_ones,
    input  logic [3:0]                  total_zeros,
    input  logic [2:0]                  t1_signs,
    output logic                        busy,
    input  logic                        elem_valid,
    output logic                        elem_ready,
    input  logic signed [RES_WIDTH-1:0] elem_level,
    input  logic [3:0]                  elem_run,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [2:0]                  out_idx,
    output logic signed [RES_WIDTH-1:0] coeff0,
    output logic signed [RES_WIDTH-1:0] coeff1,
    output logic [1:0]                  s_all,
    output logic                        err,
    output logic [1:0]                  dbg_state
);

    // Handshakes: a transfer happens on a clock edge where valid and ready are both high.
    logic [1:0]                  state_q, state_d;
    logic signed [RES_WIDTH-1:0] coeff_q [MAX_COEFF];
    logic signed [RES_WIDTH-1:0] coeff_d [MAX_COEFF];
    logic [4:0]                  pos_q, pos_d;
    logic [3:0]                  zl_q, zl_d;
    logic [4:0]                  tc_q, tc_d;
    logic [1:0]                  t1n_q, t1n_d;
    logic [2:0]                  t1s_q, t1s_d;
    logic [4:0]                  cnt_q, cnt_d;
    logic [2:0]                  idx_q, idx_d;
    logic                        err_q, err_d;

    logic signed [RES_WIDTH-1:0] level;
    logic [4:0]                  pos_next;
    logic [3:0]                  zl_next;
    logic                        last, run_err, bad;

    cavlc_coeff_place #(.RES_WIDTH(RES_WIDTH)) u_place (
        .elem_cnt_i        (cnt_q),
        .total_coeff_i     (tc_q),
        .trailing_ones_i   (t1n_q),
        .t1_signs_i        (t1s_q),
        .elem_level_i      (elem_level),
        .elem_run_i        (elem_run),
        .pos_i             (pos_q),
        .zeros_left_i      (zl_q),
        .level_o           (level),
        .pos_next_o        (pos_next),
        .zeros_left_next_o (zl_next),
        .last_o            (last),
        .run_err_o         (run_err)
    );

    assign bad = start_bad(total_coeff, trailing_ones, total_zeros);

    always_comb begin
        state_d = state_q;
        coeff_d = coeff_q;
        pos_d   = pos_q;
        zl_d    = zl_q;
        tc_d    = tc_q;
        t1n_d   = t1n_q;
        t1s_d   = t1s_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    for (int k = 0; k < MAX_COEFF; k++) coeff_d[k] = '0;
                    idx_d   = 3'd0;
                    cnt_d   = 5'd0;
                    pos_d   = total_coeff + {1'b0, total_zeros} - 5'd1;
                    zl_d    = total_zeros;
                    t1n_d   = trailing_ones;
                    t1s_d   = t1_signs;
                    err_d   = bad;
                    tc_d    = bad ? 5'd0 : total_coeff;
                    state_d = (bad || total_coeff == 5'd0) ? ST_EMIT : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (elem_valid) begin
                    coeff_d[pos_q[3:0]] = level;
                    pos_d = pos_next;
                    zl_d  = zl_next;
                    cnt_d = cnt_q + 5'd1;
                    err_d = err_q | run_err;
                    if (last) state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (out_ready) begin
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd7) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            for (int k = 0; k < MAX_COEFF; k++) coeff_q[k] <= '0;
            pos_q   <= '0;
            zl_q    <= '0;
            tc_q    <= '0;
            t1n_q   <= '0;
            t1s_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            coeff_q <= coeff_d;
            pos_q   <= pos_d;
            zl_q    <= zl_d;
            tc_q    <= tc_d;
            t1n_q   <= t1n_d;
            t1s_q   <= t1s_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign elem_ready = (state_q == ST_LOAD);
    assign out_valid  = (state_q == ST_EMIT);
    assign out_idx    = idx_q;
    assign coeff0     = coeff_q[{idx_q, 1'b0}];
    assign coeff1     = coeff_q[{idx_q, 1'b1}];
    assign s_all      = {coeff1 != '0, coeff0 != '0};
    assign err        = err_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_cavlc_coeff_rebuild.sv
// Directed, table-driven bench for cavlc_coeff_rebuild with hand-computed blocks
// plus sequences for latency, backpressure, ignored start and mid-block reset.
module tb_cavlc_coeff_rebuild;
  import cavlc_coeff_rebuild_pkg::*;

  localparam int W = 16;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         start = 1'b0;
  logic [4:0]   total_coeff = '0;
  logic [1:0]   trailing_ones = '0;
  logic [3:0]   total_zeros = '0;
  logic [2:0]   t1_signs = '0;
  logic         busy;
  logic         elem_valid = 1'b0;
  logic         elem_ready;
  logic [W-1:0] elem_level = '0;
  logic [3:0]   elem_run = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [2:0]   out_idx;
  logic [W-1:0] coeff0;
  logic [W-1:0] coeff1;
  logic [1:0]   s_all;
  logic         err;
  logic [1:0]   dbg_state;

  cavlc_coeff_rebuild #(.RES_WIDTH(W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .total_coeff   (total_coeff),
    .trailing_ones (trailing_ones),
    .total_zeros   (total_zeros),
    .t1_signs      (t1_signs),
    .busy          (busy),
    .elem_valid    (elem_valid),
    .elem_ready    (elem_ready),
    .elem_level    (elem_level),
    .elem_run      (elem_run),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_idx       (out_idx),
    .coeff0        (coeff0),
    .coeff1        (coeff1),
    .s_all         (s_all),
    .err           (err),
    .dbg_state     (dbg_state)
  );

  typedef struct packed {
    logic [4:0]           tc;
    logic [1:0]           t1;
    logic [3:0]           tz;
    logic [2:0]           signs;
    logic [4:0]           n_elem;
    logic [15:0][W-1:0]   levels;
    logic [15:0][3:0]     runs;
    logic [15:0][W-1:0]   exp_coeff;
    logic                 exp_err;
  } vec_t;

  vec_t vecs [8];
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic do_start(input vec_t v);
    total_coeff   = v.tc;
    trailing_ones = v.t1;
    total_zeros   = v.tz;
    t1_signs      = v.signs;
    start         = 1'b1;
    tick();
    start         = 1'b0;
  endtask

  task automatic send_elem(input logic [W-1:0] lvl, input logic [3:0] run, input string tag);
    int n;
    n = 0;
    elem_valid = 1'b1;
    elem_level = lvl;
    elem_run   = run;
    while (!elem_ready && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_elem_ready"}, 32'(elem_ready), 32'd1);
    tick();
    elem_valid = 1'b0;
  endtask

  // scoreboard side: pops expected coefficients pairwise as the DUT emits them
  task automatic collect_block(input string tag, input logic exp_err, input int stall_idx,
                               input int start_idx);
    int n;
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    for (int p = 0; p < 8; p++) begin
      logic [W-1:0] e0;
      logic [W-1:0] e1;
      e0 = exp_q.pop_front();
      e1 = exp_q.pop_front();
      if (p == stall_idx) begin
        for (int s = 0; s < 3; s++) begin
          tick();
          check({tag, "_stall_idx"}, 32'(out_idx), 32'(p));
          check({tag, "_stall_c0"}, 32'(coeff0), 32'(e0));
          check({tag, "_stall_c1"}, 32'(coeff1), 32'(e1));
          check({tag, "_stall_valid"}, 32'(out_valid), 32'd1);
        end
      end
      check({tag, "_idx"}, 32'(out_idx), 32'(p));
      check({tag, "_coeff0"}, 32'(coeff0), 32'(e0));
      check({tag, "_coeff1"}, 32'(coeff1), 32'(e1));
      check({tag, "_s_all"}, 32'(s_all), 32'({e1 != '0, e0 != '0}));
      check({tag, "_pair_valid"}, 32'(out_valid), 32'd1);
      if (p == 0) check({tag, "_err"}, 32'(err), 32'(exp_err));
      if (p == start_idx) begin
        total_coeff   = 5'd0;
        trailing_ones = 2'd0;
        total_zeros   = 4'd0;
        start         = 1'b1;
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      start     = 1'b0;
    end
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
    check({tag, "_err_after"}, 32'(err), 32'(exp_err));
  endtask

  task automatic run_vector(input vec_t v, input string tag, input bit toggle,
                            input int stall_idx, input int start_idx);
    for (int k = 0; k < 16; k++) exp_q.push_back(v.exp_coeff[k]);
    do_start(v);
    for (int i = 0; i < 16; i++) begin
      if (i < int'(v.n_elem)) begin
        send_elem(v.levels[i], v.runs[i], tag);
        if (toggle) tick();
      end
    end
    collect_block(tag, v.exp_err, stall_idx, start_idx);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_elem_ready"}, 32'(elem_ready), 32'd0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_idx"}, 32'(out_idx), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_coeff0"}, 32'(coeff0), 32'd0);
    check({tag, "_coeff1"}, 32'(coeff1), 32'd0);
    check({tag, "_s_all"}, 32'(s_all), 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
  endtask

  initial begin
    int lat;

    // vector table: levels/runs listed in reverse zigzag order
    for (int i = 0; i < 8; i++) vecs[i] = '0;

    // normal block; trailing-one levels and last run are don't-care junk
    vecs[0].tc = 5'd5; vecs[0].t1 = 2'd3; vecs[0].tz = 4'd4; vecs[0].signs = 3'b100;
    vecs[0].n_elem = 5'd5;
    vecs[0].levels[0] = 16'h7777; vecs[0].levels[1] = 16'h7777; vecs[0].levels[2] = 16'h7777;
    vecs[0].levels[3] = 16'hFFFF; vecs[0].levels[4] = 16'd3;
    vecs[0].runs[0] = 4'd1; vecs[0].runs[2] = 4'd2; vecs[0].runs[4] = 4'hF;
    vecs[0].exp_coeff[1] = 16'd3; vecs[0].exp_coeff[2] = 16'hFFFF; vecs[0].exp_coeff[5] = 16'hFFFF;
    vecs[0].exp_coeff[6] = 16'd1; vecs[0].exp_coeff[8] = 16'd1;

    // full block: levels 1..16 highest frequency first
    vecs[1].tc = 5'd16; vecs[1].n_elem = 5'd16;
    for (int i = 0; i < 16; i++) begin
      vecs[1].levels[i] = 16'(i + 1);
      vecs[1].exp_coeff[i] = 16'(16 - i);
    end

    // total_coeff + total_zeros > 16
    vecs[2].tc = 5'd10; vecs[2].tz = 4'd8; vecs[2].exp_err = 1'b1;

    // run 5 with zeros_left 2: clamped to 2
    vecs[3].tc = 5'd3; vecs[3].tz = 4'd2; vecs[3].n_elem = 5'd3;
    vecs[3].levels[0] = 16'd5; vecs[3].levels[1] = 16'd6; vecs[3].levels[2] = 16'd7;
    vecs[3].runs[0] = 4'd5;
    vecs[3].exp_coeff[0] = 16'd7; vecs[3].exp_coeff[1] = 16'd6; vecs[3].exp_coeff[4] = 16'd5;
    vecs[3].exp_err = 1'b1;

    // single negative trailing one; clears the previous err
    vecs[4].tc = 5'd1; vecs[4].t1 = 2'd1; vecs[4].signs = 3'b001; vecs[4].n_elem = 5'd1;
    vecs[4].levels[0] = 16'h1234;
    vecs[4].exp_coeff[0] = 16'hFFFF;

    // trailing_ones > total_coeff
    vecs[5].tc = 5'd2; vecs[5].t1 = 2'd3; vecs[5].exp_err = 1'b1;

    // mixed trailing ones and levels
    vecs[6].tc = 5'd4; vecs[6].t1 = 2'd2; vecs[6].tz = 4'd3; vecs[6].signs = 3'b010;
    vecs[6].n_elem = 5'd4;
    vecs[6].levels[2] = 16'hFFF9; vecs[6].levels[3] = 16'd9;
    vecs[6].runs[0] = 4'd1; vecs[6].runs[2] = 4'd2;
    vecs[6].exp_coeff[0] = 16'd9; vecs[6].exp_coeff[3] = 16'hFFF9;
    vecs[6].exp_coeff[4] = 16'hFFFF; vecs[6].exp_coeff[6] = 16'd1;

    // oversized run on the last element is ignored (no err)
    vecs[7].tc = 5'd2; vecs[7].tz = 4'd1; vecs[7].n_elem = 5'd2;
    vecs[7].levels[0] = 16'd4; vecs[7].levels[1] = 16'hFFFC;
    vecs[7].runs[1] = 4'd7;
    vecs[7].exp_coeff[1] = 16'hFFFC; vecs[7].exp_coeff[2] = 16'd4;

    #1;
    check_reset_values("reset_held");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check_reset_values("reset_release");

    for (int v = 0; v < 8; v++) begin
      run_vector(vecs[v], $sformatf("vec%0d", v), 1'b0, -1, -1);
    end

    // empty block: start-to-idle of 9 cycles, never asks for elements
    for (int k = 0; k < 16; k++) exp_q.push_back('0);
    total_coeff = 5'd0; trailing_ones = 2'd0; total_zeros = 4'd0; t1_signs = 3'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
    out_ready = 1'b1;
    while (busy && lat < 30) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      check("empty_elem_ready", 32'(elem_ready), 32'd0);
      check("empty_out_valid", 32'(out_valid), 32'd1);
      check("empty_coeff0", 32'(coeff0), 32'(e));
      e = exp_q.pop_front();
      check("empty_coeff1", 32'(coeff1), 32'(e));
      tick();
      lat++;
    end
    out_ready = 1'b0;
    check("empty_latency", 32'(lat), 32'd9);
    exp_q.delete();

    // elem_valid toggling and a 3-cycle out_ready stall at idx 2
    run_vector(vecs[0], "backpressure", 1'b1, 2, -1);

    // start pulsed during EMIT must not disturb the block nor restart afterwards
    run_vector(vecs[6], "start_in_emit", 1'b0, -1, 3);
    tick();
    check("start_in_emit_stay_idle", 32'(busy), 32'd0);

    // reset during LOAD after two elements (err already set by the clamped run)
    do_start(vecs[3]);
    send_elem(vecs[3].levels[0], vecs[3].runs[0], "midreset");
    send_elem(vecs[3].levels[1], vecs[3].runs[1], "midreset");
    check("midreset_err_before", 32'(err), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_values("midreset");
    tick();
    rst_n = 1'b1;
    tick();
    run_vector(vecs[0], "after_reset", 1'b0, -1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
